turn_sequencer: RTL

TURN_SEQUENCER -- requirements
Module: turn_sequencer

---
 rtl/turn_sequencer_if.sv | 34 +++
 rtl/turn_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/turn_sequencer_if.sv
// Purpose: groups the game-control inputs and the turn/status outputs of turn_sequencer.
// Ports: slave modport = the sequencer (takes start/move/judge verdicts, drives status);
//        master modport = the game controller / judge side that drives the inputs.
interface turn_sequencer_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int PW          = 2
);
  logic                   start;
  logic                   move_valid;
  logic                   ill_move;
  logic                   win;
  logic                   no_space;
  logic                   restart;
  logic [NUM_PLAYERS-1:0] player_en;
  logic [PW-1:0]          active_player;
  logic [3:0]             strikes;
  logic                   timeout_pulse;
  logic                   game_over;
  logic [PW-1:0]          winner;
  logic                   winner_valid;
  logic                   draw;

  modport slave (
    input  start, move_valid, ill_move, win, no_space, restart,
    output player_en, active_player, strikes, timeout_pulse,
           game_over, winner, winner_valid, draw
  );

  modport master (
    output start, move_valid, ill_move, win, no_space, restart,
    input  player_en, active_player, strikes, timeout_pulse,
           game_over, winner, winner_valid, draw
  );
endinterface

// File: rtl/turn_sequencer.sv
// Purpose: turn-based game sequencer; rotates players, counts illegal-move strikes,
//          forfeits turns on timeout and records win/draw outcomes.
// Latency: every output is registered; an input is reflected one clk edge later.
// Backpressure: none; move_valid is honoured only in TURN, verdicts only in CHECK,
//          start only in IDLE and restart only in GAME_OVER, everything else is dropped.
// Ports: clk, reset_n (async active-low), bus (turn_sequencer_if.slave).
module turn_sequencer #(
  parameter int NUM_PLAYERS = 2,
  parameter int PW          = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_STRIKES = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  turn_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, TURN, CHECK, GAME_OVER} state_t;

  // Timer only needs to reach TIMEOUT_CYC-1.
  localparam int             TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]  TLAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [PW-1:0]  PLAST = PW'(NUM_PLAYERS - 1);
  localparam logic [3:0]     SMAX  = 4'(MAX_STRIKES);
  localparam bit             TO_EN = (TIMEOUT_CYC != 0);

  state_t                 state_q, state_d;
  logic [PW-1:0]          active_q, active_d;
  logic [PW-1:0]          first_q, first_d;
  logic [3:0]             strikes_q, strikes_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   tpulse_q, tpulse_d;
  logic                   go_q, go_d;
  logic [PW-1:0]          winner_q, winner_d;
  logic                   wvalid_q, wvalid_d;
  logic                   draw_q, draw_d;
  logic [NUM_PLAYERS-1:0] pen_q, pen_d;
  logic [3:0]             strikes_inc;

  function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      active_q  <= '0;
      first_q   <= '0;
      strikes_q <= '0;
      timer_q   <= '0;
      tpulse_q  <= 1'b0;
      go_q      <= 1'b0;
      winner_q  <= '0;
      wvalid_q  <= 1'b0;
      draw_q    <= 1'b0;
      pen_q     <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      first_q   <= first_d;
      strikes_q <= strikes_d;
      timer_q   <= timer_d;
      tpulse_q  <= tpulse_d;
      go_q      <= go_d;
      winner_q  <= winner_d;
      wvalid_q  <= wvalid_d;
      draw_q    <= draw_d;
      pen_q     <= pen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    first_d     = first_q;
    strikes_d   = strikes_q;
    timer_d     = '0;          // cleared whenever TURN is (re)entered or left
    tpulse_d    = 1'b0;
    winner_d    = winner_q;
    wvalid_d    = wvalid_q;
    draw_d      = draw_q;
    strikes_inc = strikes_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = TURN;
          active_d  = first_q;
          strikes_d = '0;
        end
      end
      TURN: begin
        // A move arriving on the expiry cycle beats the timeout.
        if (bus.move_valid) begin
          state_d = CHECK;
        end else if (TO_EN && timer_q == TLAST) begin
          tpulse_d  = 1'b1;
          active_d  = advance(active_q);
          strikes_d = '0;
        end else if (TO_EN) begin
          timer_d = timer_q + 1'b1;
        end
      end
      CHECK: begin
        if (bus.win) begin
          state_d  = GAME_OVER;
          winner_d = active_q;
          wvalid_d = 1'b1;
          draw_d   = 1'b0;
        end else if (bus.no_space) begin
          state_d  = GAME_OVER;
          wvalid_d = 1'b0;
          draw_d   = 1'b1;
        end else if (bus.ill_move) begin
          state_d = TURN;
          if (strikes_inc == SMAX) begin
            active_d  = advance(active_q);
            strikes_d = '0;
          end else begin
            strikes_d = strikes_inc;
          end
        end else begin
          state_d   = TURN;
          active_d  = advance(active_q);
          strikes_d = '0;
        end
      end
      GAME_OVER: begin
        if (bus.restart) begin
          state_d   = IDLE;
          wvalid_d  = 1'b0;
          draw_d    = 1'b0;
          strikes_d = '0;
          first_d   = advance(first_q);  // next game opens with the next player
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are derived from the next state so they register in step with it.
    go_d  = (state_d == GAME_OVER);
    pen_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      pen_d[i] = (state_d == TURN) && (active_d == PW'(i));
    end
  end

  assign bus.player_en     = pen_q;
  assign bus.active_player = active_q;
  assign bus.strikes       = strikes_q;
  assign bus.timeout_pulse = tpulse_q;
  assign bus.game_over     = go_q;
  assign bus.winner        = winner_q;
  assign bus.winner_valid  = wvalid_q;
  assign bus.draw          = draw_q;

endmodule
